fb_write_sequencer: RTL and testbench
=====================================

Name: fb_write_sequencer

Overview:
- Sits between the SPI slave receiver and the frame-buffer memory arbiter.
- Consumes decoded CASET/RASET windows, command bytes and 16-bit pixel pulses from the receiver.
- Tracks the ST7735-style write cursor inside the active window and turns each pixel into a linear frame-buffer address.
- Queues {address, pixel} pairs in a small FIFO and drains them to the memory side over a req/ack handshake.

Parameters:
H_RES, 480, display width in pixels (linear address = y*H_RES + x)
V_RES, 272, display height in pixels
ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
FIFO_DEPTH, 4, number of {addr,data} entries; power of two, >= 2

Ports:
i_clk  in  1  system clock (same domain as receiver outputs)
i_rst  in  1  asynchronous active-high reset
i_inst_data  in  8  last command byte
i_inst_en_pls  in  1  one-cycle command-received pulse
i_col_addr  in  32  XS[31:16], XE[15:0]
i_col_addr_en_pls  in  1  column window valid pulse
i_row_addr  in  32  YS[31:16], YE[15:0]
i_row_addr_en_pls  in  1  row window valid pulse
i_pixel_data  in  16  RGB565 pixel
i_pixel_en_pls  in  1  one-cycle pixel valid pulse
i_wr_ack  in  1  memory side accepted current entry
o_wr_req  out  1  FIFO head valid
o_wr_addr  out  ADDR_W  linear address of FIFO head
o_wr_data  out  16  pixel of FIFO head
o_frame_done  out  1  one-cycle pulse when pixel (XE,YE) is enqueued
o_fifo_ovf  out  1  sticky: pixel dropped because FIFO full
o_win_err  out  1  sticky: RAMWR issued with invalid window

Behaviour:
- Reset (async, i_rst=1): window = XS=0, XE=H_RES-1, YS=0, YE=V_RES-1; state IDLE; cursor (0,0); FIFO empty. All outputs 0.
- Window registers: on i_col_addr_en_pls latch XS/XE; on i_row_addr_en_pls latch YS/YE. New values do not move the cursor until the next RAMWR.
- Window valid = XS<=XE && YS<=YE && XE<H_RES && YE<V_RES.
- FSM states: IDLE, SETUP, WRITE, REJECT.
- Command pulse handling:
  - 0x2C (RAMWR): go to SETUP, cursor x=XS, y=YS.
    - If the window is valid, clear o_win_err.
    - If the window is invalid, set o_win_err and go to REJECT instead.
  - 0x3C (RAMWR continue): from IDLE or WRITE go to WRITE with the cursor kept. From REJECT stay in REJECT.
  - Any other command: go to IDLE.
- SETUP: one cycle. Registers line_base = YS*H_RES, then goes to WRITE. A pixel pulse that arrives while in SETUP is held in a 1-entry skid register and enqueued in the first WRITE cycle.
- Pixel pulses in IDLE or REJECT are dropped silently (no flag).
- WRITE, per pixel pulse:
  - Enqueue {line_base + x, i_pixel_data}; the entry is visible at the FIFO head at the earliest the next cycle.
  - Then advance the cursor:
    - x<XE: x+1.
    - x==XE and y<YE: x=XS, y+1, line_base += H_RES.
    - x==XE and y==YE: pulse o_frame_done; wrap to x=XS, y=YS, line_base = YS*H_RES (stay in WRITE).
- Address arithmetic: unsigned, ADDR_W bits. It cannot overflow while the window is valid.
- FIFO is first-word-fall-through:
  - o_wr_req = !empty.
  - o_wr_addr/o_wr_data hold stable while o_wr_req=1 and i_wr_ack=0.
  - i_wr_ack with o_wr_req=1 pops the head. i_wr_ack while empty is ignored.
- Full FIFO, push without a same-cycle pop: the pixel is dropped, o_fifo_ovf is set, and the cursor still advances.
- Full FIFO, push with a same-cycle pop: both happen; occupancy is unchanged.
- o_fifo_ovf and o_win_err clear only on reset (o_win_err is also cleared by a valid RAMWR).
- Command pulse in the same cycle as a window pulse: the window latches first, so RAMWR uses the new window.
- Reset asserted mid-operation: FIFO contents are discarded and o_wr_req deasserts immediately (async).

Test Plan:
- Reset, CASET 0x0000_01DF, RASET 0x0000_010F, RAMWR, 3 pixels 0xF800/0x07E0/0x001F with ack tied high -> writes at addr 0,1,2 with matching data in order.
- Window XS=10,XE=11,YS=5,YE=6, RAMWR, 5 pixels -> addrs 2410,2411,2890,2891,2410. o_frame_done pulses once, on the 4th pixel.
- Hold i_wr_ack=0, send 6 pixels, FIFO_DEPTH=4 -> o_wr_req stays high with addr/data stable. o_fifo_ovf=1 and pixels 5 and 6 are lost. Releasing ack drains exactly 4 entries.
- CASET XS=20,XE=10 then RAMWR -> o_win_err=1, no o_wr_req on following pixels. A valid CASET followed by RAMWR clears o_win_err.
- RAMWR, 2 pixels, then command 0x29, 1 pixel, then 0x3C, 1 pixel -> the pixel after 0x29 is dropped; 0x3C resumes at the 3rd cursor position.
- Assert i_rst with 3 entries queued -> o_wr_req drops immediately. After release, flags and outputs are 0 and the window is full-screen.

Source files
------------

// File: rtl/fb_write_sequencer.sv
// Turns ST7735 RAMWR pixel pulses into {linear address, pixel} frame-buffer writes queued in a FWFT FIFO.
// Latency: pixel to o_wr_req 1 cycle (2 if it lands in SETUP); backpressure via i_wr_ack, full queue drops pixel and flags o_fifo_ovf.

// Generic first-word-fall-through FIFO; head valid the cycle after push, full push with same-cycle pop accepted.
module fb_wseq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_vld,
   output logic             wr_rdy,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             rd_vld,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             push;
   logic             pop;

   assign rd_vld = (cnt != '0);
   assign wr_rdy = (cnt != FULL_CNT) || rd_rdy;
   assign push   = wr_vld && wr_rdy;
   assign pop    = rd_vld && rd_rdy;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

module fb_write_sequencer #(
   parameter int H_RES      = 480,
   parameter int V_RES      = 272,
   parameter int ADDR_W     = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_inst_data,
   input  logic              i_inst_en_pls,
   input  logic [31:0]       i_col_addr,
   input  logic              i_col_addr_en_pls,
   input  logic [31:0]       i_row_addr,
   input  logic              i_row_addr_en_pls,
   input  logic [15:0]       i_pixel_data,
   input  logic              i_pixel_en_pls,
   input  logic              i_wr_ack,
   output logic              o_wr_req,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [15:0]       o_wr_data,
   output logic              o_frame_done,
   output logic              o_fifo_ovf,
   output logic              o_win_err
);
   typedef enum logic [1:0] {IDLE, SETUP, WRITE, REJECT} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       pix;
   } wr_ent_t;

   localparam logic [15:0]       H_RES_C   = 16'(H_RES);
   localparam logic [15:0]       V_RES_C   = 16'(V_RES);
   localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_RES);
   localparam logic [7:0]        CMD_RAMWR = 8'h2C;
   localparam logic [7:0]        CMD_RAMWC = 8'h3C;

   state_t            state;
   logic [15:0]       xs, xe, ys, ye;
   logic [15:0]       act_xs, act_xe, act_ys, act_ye;
   logic [15:0]       cur_x, cur_y;
   logic [ADDR_W-1:0] line_base;
   logic [ADDR_W-1:0] ys_base;
   logic [ADDR_W-1:0] ys_mul;
   logic              skid_vld;
   logic [15:0]       skid_dat;
   logic [15:0]       xs_n, xe_n, ys_n, ye_n;
   logic              win_ok;
   logic              px_vld;
   logic [15:0]       px_dat;
   logic              push_vld;
   logic              push_rdy;
   wr_ent_t           push_ent;
   wr_ent_t           head_ent;
   logic              head_vld;

   // A window pulse coincident with RAMWR must be seen by that RAMWR.
   assign xs_n = i_col_addr_en_pls ? i_col_addr[31:16] : xs;
   assign xe_n = i_col_addr_en_pls ? i_col_addr[15:0]  : xe;
   assign ys_n = i_row_addr_en_pls ? i_row_addr[31:16] : ys;
   assign ye_n = i_row_addr_en_pls ? i_row_addr[15:0]  : ye;

   assign win_ok = (xs_n <= xe_n) && (ys_n <= ye_n) && (xe_n < H_RES_C) && (ye_n < V_RES_C);
   assign ys_mul = ADDR_W'(act_ys) * H_STEP;

   assign px_vld        = skid_vld || i_pixel_en_pls;
   assign px_dat        = skid_vld ? skid_dat : i_pixel_data;
   assign push_vld      = (state == WRITE) && px_vld;
   assign push_ent.addr = line_base + ADDR_W'(cur_x);
   assign push_ent.pix  = px_dat;

   fb_wseq_fifo #(
      .WIDTH ($bits(wr_ent_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (i_clk),
      .rst    (i_rst),
      .wr_vld (push_vld),
      .wr_rdy (push_rdy),
      .wr_dat (push_ent),
      .rd_vld (head_vld),
      .rd_rdy (i_wr_ack),
      .rd_dat (head_ent)
   );

   assign o_wr_req  = head_vld;
   assign o_wr_addr = head_vld ? head_ent.addr : '0;
   assign o_wr_data = head_vld ? head_ent.pix  : '0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         xs           <= '0;
         xe           <= H_RES_C - 16'd1;
         ys           <= '0;
         ye           <= V_RES_C - 16'd1;
         act_xs       <= '0;
         act_xe       <= H_RES_C - 16'd1;
         act_ys       <= '0;
         act_ye       <= V_RES_C - 16'd1;
         cur_x        <= '0;
         cur_y        <= '0;
         line_base    <= '0;
         ys_base      <= '0;
         skid_vld     <= 1'b0;
         skid_dat     <= '0;
         o_frame_done <= 1'b0;
         o_fifo_ovf   <= 1'b0;
         o_win_err    <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         xs <= xs_n;
         xe <= xe_n;
         ys <= ys_n;
         ye <= ye_n;

         if (push_vld && !push_rdy) o_fifo_ovf <= 1'b1;

         case (state)
            SETUP: begin
               line_base <= ys_mul;
               ys_base   <= ys_mul;
               state     <= WRITE;
               if (i_pixel_en_pls) begin
                  skid_vld <= 1'b1;
                  skid_dat <= i_pixel_data;
               end
            end
            WRITE: begin
               // Skid drains first; a pulse landing on that cycle takes its place.
               skid_vld <= skid_vld && i_pixel_en_pls;
               if (skid_vld && i_pixel_en_pls) skid_dat <= i_pixel_data;
               if (px_vld) begin
                  if (cur_x != act_xe) begin
                     cur_x <= cur_x + 16'd1;
                  end else if (cur_y != act_ye) begin
                     cur_x     <= act_xs;
                     cur_y     <= cur_y + 16'd1;
                     line_base <= line_base + H_STEP;
                  end else begin
                     o_frame_done <= 1'b1;
                     cur_x        <= act_xs;
                     cur_y        <= act_ys;
                     line_base    <= ys_base;
                  end
               end
            end
            default: skid_vld <= 1'b0;
         endcase

         if (i_inst_en_pls) begin
            case (i_inst_data)
               CMD_RAMWR: begin
                  act_xs   <= xs_n;
                  act_xe   <= xe_n;
                  act_ys   <= ys_n;
                  act_ye   <= ye_n;
                  cur_x    <= xs_n;
                  cur_y    <= ys_n;
                  skid_vld <= 1'b0;
                  if (win_ok) begin
                     state     <= SETUP;
                     o_win_err <= 1'b0;
                  end else begin
                     state     <= REJECT;
                     o_win_err <= 1'b1;
                  end
               end
               CMD_RAMWC: begin
                  if (state != REJECT) state <= WRITE;
               end
               default: begin
                  state    <= IDLE;
                  skid_vld <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fb_write_sequencer.sv
// Directed bench for fb_write_sequencer: window mapping, FIFO backpressure/overflow, window errors, resume and reset.
module tb_fb_write_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  inst_dat;
   logic        inst_en;
   logic [31:0] col_addr;
   logic        col_en;
   logic [31:0] row_addr;
   logic        row_en;
   logic [15:0] pix_dat;
   logic        pix_en;
   logic        wr_ack;
   logic        wr_req;
   logic [16:0] wr_addr;
   logic [15:0] wr_data;
   logic        frame_done;
   logic        fifo_ovf;
   logic        win_err;

   int total = 0;
   int bad = 0;
   int fd_cnt = 0;
   logic [32:0] wq[$];

   always #5 clk = ~clk;

   fb_write_sequencer #(
      .H_RES(480), .V_RES(272), .ADDR_W(17), .FIFO_DEPTH(4)
   ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_inst_data       (inst_dat),
      .i_inst_en_pls     (inst_en),
      .i_col_addr        (col_addr),
      .i_col_addr_en_pls (col_en),
      .i_row_addr        (row_addr),
      .i_row_addr_en_pls (row_en),
      .i_pixel_data      (pix_dat),
      .i_pixel_en_pls    (pix_en),
      .i_wr_ack          (wr_ack),
      .o_wr_req          (wr_req),
      .o_wr_addr         (wr_addr),
      .o_wr_data         (wr_data),
      .o_frame_done      (frame_done),
      .o_fifo_ovf        (fifo_ovf),
      .o_win_err         (win_err)
   );

   // Record every accepted write and every frame_done pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_req && wr_ack) wq.push_back({wr_addr, wr_data});
      if (frame_done) fd_cnt++;
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input int idx, input logic [16:0] a, input logic [15:0] d);
      if (idx < wq.size()) chk(tag, 40'(wq[idx]), 40'({a, d}));
      else chk({tag, "_missing"}, 40'(wq.size()), 40'(idx + 1));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [7:0] c);
      inst_dat = c; inst_en = 1'b1; tick(); inst_en = 1'b0;
   endtask

   task automatic caset(input logic [31:0] v);
      col_addr = v; col_en = 1'b1; tick(); col_en = 1'b0;
   endtask

   task automatic raset(input logic [31:0] v);
      row_addr = v; row_en = 1'b1; tick(); row_en = 1'b0;
   endtask

   task automatic pixel(input logic [15:0] d);
      pix_dat = d; pix_en = 1'b1; tick(); pix_en = 1'b0; tick();
   endtask

   initial begin
      int fd0;
      rst = 1'b1; inst_dat = '0; inst_en = 1'b0; col_addr = '0; col_en = 1'b0;
      row_addr = '0; row_en = 1'b0; pix_dat = '0; pix_en = 1'b0; wr_ack = 1'b1;
      tick(); tick();
      chk("rst_req", wr_req, 0);
      chk("rst_addr", wr_addr, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_ovf", fifo_ovf, 0);
      chk("rst_werr", win_err, 0);
      rst = 1'b0; tick();

      // Full-screen window, three pixels drained immediately
      wq.delete();
      caset(32'h0000_01DF); raset(32'h0000_010F); cmd(8'h2C);
      pixel(16'hF800); pixel(16'h07E0); pixel(16'h001F);
      repeat (4) tick();
      chk("t1_cnt", wq.size(), 3);
      chk_wr("t1_w0", 0, 17'd0, 16'hF800);
      chk_wr("t1_w1", 1, 17'd1, 16'h07E0);
      chk_wr("t1_w2", 2, 17'd2, 16'h001F);

      // 2x2 window at (10,5): row stride and frame wrap
      wq.delete();
      caset(32'h000A_000B); raset(32'h0005_0006); cmd(8'h2C);
      fd0 = fd_cnt;
      pixel(16'h1001); pixel(16'h1002); pixel(16'h1003);
      chk("t2_fd_before", fd_cnt - fd0, 0);
      pixel(16'h1004);
      chk("t2_fd_on4", fd_cnt - fd0, 1);
      pixel(16'h1005);
      chk("t2_fd_after5", fd_cnt - fd0, 1);
      repeat (3) tick();
      chk("t2_cnt", wq.size(), 5);
      chk_wr("t2_w0", 0, 17'd2410, 16'h1001);
      chk_wr("t2_w1", 1, 17'd2411, 16'h1002);
      chk_wr("t2_w2", 2, 17'd2890, 16'h1003);
      chk_wr("t2_w3", 3, 17'd2891, 16'h1004);
      chk_wr("t2_w4", 4, 17'd2410, 16'h1005);

      // Backpressure: 6 pixels into a 4-deep queue with ack held low
      wr_ack = 1'b0; wq.delete();
      cmd(8'h2C);
      pixel(16'hA001);
      chk("t3_req1", wr_req, 1);
      chk("t3_addr1", wr_addr, 2410);
      chk("t3_data1", wr_data, 16'hA001);
      pixel(16'hA002); pixel(16'hA003); pixel(16'hA004);
      chk("t3_ovf_at_full", fifo_ovf, 0);
      pixel(16'hA005); pixel(16'hA006);
      chk("t3_req_held", wr_req, 1);
      chk("t3_addr_held", wr_addr, 2410);
      chk("t3_data_held", wr_data, 16'hA001);
      chk("t3_ovf", fifo_ovf, 1);
      chk("t3_no_pop", wq.size(), 0);
      wr_ack = 1'b1;
      repeat (8) tick();
      chk("t3_drain_cnt", wq.size(), 4);
      chk_wr("t3_d0", 0, 17'd2410, 16'hA001);
      chk_wr("t3_d1", 1, 17'd2411, 16'hA002);
      chk_wr("t3_d2", 2, 17'd2890, 16'hA003);
      chk_wr("t3_d3", 3, 17'd2891, 16'hA004);
      chk("t3_empty", wr_req, 0);

      // Full queue, push and pop in the same cycle: both happen
      wr_ack = 1'b0; wq.delete();
      pixel(16'hB001); pixel(16'hB002); pixel(16'hB003); pixel(16'hB004);
      pix_dat = 16'hB005; pix_en = 1'b1; wr_ack = 1'b1; tick();
      pix_en = 1'b0; wr_ack = 1'b0; tick();
      chk("tf_pop_cnt", wq.size(), 1);
      chk_wr("tf_pop", 0, 17'd2890, 16'hB001);
      chk("tf_head_addr", wr_addr, 2891);
      chk("tf_head_data", wr_data, 16'hB002);
      wq.delete(); wr_ack = 1'b1;
      repeat (8) tick();
      chk("tf_drain_cnt", wq.size(), 4);
      chk_wr("tf_d0", 0, 17'd2891, 16'hB002);
      chk_wr("tf_d1", 1, 17'd2410, 16'hB003);
      chk_wr("tf_d2", 2, 17'd2411, 16'hB004);
      chk_wr("tf_d3", 3, 17'd2890, 16'hB005);

      // Window errors
      wq.delete();
      caset(32'h0014_000A); cmd(8'h2C);
      chk("t4_werr_xs_gt_xe", win_err, 1);
      pixel(16'hD001); pixel(16'hD002);
      repeat (3) tick();
      chk("t4_rejected", wq.size(), 0);
      chk("t4_req", wr_req, 0);
      caset(32'h0000_0003); cmd(8'h2C);
      chk("t4_werr_clear", win_err, 0);
      caset(32'h0000_01E0); cmd(8'h2C);
      chk("t4_werr_xe_480", win_err, 1);
      caset(32'h0000_0003); cmd(8'h2C);
      chk("t4_werr_clear2", win_err, 0);

      // Non-write command pauses, 0x3C resumes at the kept cursor
      wq.delete();
      cmd(8'h2C);
      pixel(16'hC001); pixel(16'hC002);
      cmd(8'h29);
      pixel(16'hC003);
      cmd(8'h3C);
      pixel(16'hC004);
      repeat (3) tick();
      chk("t5_cnt", wq.size(), 3);
      chk_wr("t5_w0", 0, 17'd2400, 16'hC001);
      chk_wr("t5_w1", 1, 17'd2401, 16'hC002);
      chk_wr("t5_w2", 2, 17'd2402, 16'hC004);

      // CASET and RAMWR on the same cycle: RAMWR uses the new window
      wq.delete();
      col_addr = 32'h0007_0007; col_en = 1'b1; inst_dat = 8'h2C; inst_en = 1'b1;
      tick();
      col_en = 1'b0; inst_en = 1'b0;
      pixel(16'hE001); pixel(16'hE002);
      repeat (3) tick();
      chk_wr("t5_same_w0", 0, 17'd2407, 16'hE001);
      chk_wr("t5_same_w1", 1, 17'd2887, 16'hE002);

      // Asynchronous reset with entries queued
      wr_ack = 1'b0; wq.delete();
      pixel(16'hF001); pixel(16'hF002); pixel(16'hF003);
      chk("t6_req_before", wr_req, 1);
      @(posedge clk); #3;
      rst = 1'b1; #1;
      chk("t6_req_async", wr_req, 0);
      tick(); tick();
      rst = 1'b0; tick();
      chk("t6_ovf", fifo_ovf, 0);
      chk("t6_werr", win_err, 0);
      chk("t6_fd", frame_done, 0);
      chk("t6_req", wr_req, 0);
      chk("t6_addr", wr_addr, 0);
      chk("t6_data", wr_data, 0);
      wr_ack = 1'b1; wq.delete();
      cmd(8'h2C);
      pixel(16'h1111); pixel(16'h2222);
      repeat (3) tick();
      chk("t6_cnt", wq.size(), 2);
      chk_wr("t6_w0", 0, 17'd0, 16'h1111);
      chk_wr("t6_w1", 1, 17'd1, 16'h2222);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
